// File: rtl/des_crc_rx_pkg.sv
// Shared frame constants and receiver state encoding for the payload+CRC serial link.
// The transmit-side CRC and serializer use the same values.
package des_crc_rx_pkg;

   localparam int              PAYLOAD_W = 32;
   localparam int              CRC_W     = 16;
   localparam int              CNT_W     = 6;
   localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
   localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CRC     = 2'd2,
      DONE    = 2'd3
   } rx_state_t;

endpackage

// File: rtl/des_crc_rx_crc16_lfsr_step.sv
// One serial step of the MSB-first CRC-16 LFSR (implicit x^16, no reflection).
// Combinational, zero latency; no flow control.
module crc16_lfsr_step
   import des_crc_rx_pkg::*;
(
   input  logic [CRC_W-1:0] lfsr_in,
   input  logic             din,
   input  logic [CRC_W-1:0] poly,
   output logic [CRC_W-1:0] lfsr_out
);

   logic fb;

   assign fb       = lfsr_in[CRC_W-1] ^ din;
   assign lfsr_out = {lfsr_in[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);

endmodule

// File: rtl/des_crc_rx.sv
// Serial frame receiver: reassembles payload + CRC and checks the recomputed CRC.
// data_valid one clk after the last bit is sampled; no backpressure, serial_valid gaps stall.
module des_crc_rx
   import des_crc_rx_pkg::*;
(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 mode,
   input  logic                 frame_start,
   input  logic                 serial_valid,
   input  logic                 serial_in,
   output logic [PAYLOAD_W-1:0] data_out,
   output logic [CRC_W-1:0]     crc_rx,
   output logic [CRC_W-1:0]     crc_calc,
   output logic                 data_valid,
   output logic                 crc_err,
   output logic                 busy
);

   rx_state_t            state;
   logic [CNT_W-1:0]     cnt;
   logic [PAYLOAD_W-1:0] pay_sr;
   logic [CRC_W-1:0]     crc_sr;
   logic [CRC_W-1:0]     lfsr;
   logic                 mode_q;

   logic                 start_vld;
   logic [PAYLOAD_W-1:0] pay_nxt;
   logic [CRC_W-1:0]     crc_nxt;
   logic [CRC_W-1:0]     lfsr_seed;
   logic [CRC_W-1:0]     lfsr_nxt;

   // A qualified frame_start restarts from any state, so the step always sees the seed then.
   assign start_vld = frame_start & serial_valid;
   assign pay_nxt   = {pay_sr[PAYLOAD_W-2:0], serial_in};
   assign crc_nxt   = {crc_sr[CRC_W-2:0], serial_in};
   assign lfsr_seed = start_vld ? CRC_INIT : lfsr;

   crc16_lfsr_step u_lfsr_step (
      .lfsr_in  (lfsr_seed),
      .din      (serial_in),
      .poly     (CRC_POLY),
      .lfsr_out (lfsr_nxt)
   );

   // Results are registered on the edge that takes the last bit so they are visible during DONE.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         cnt        <= '0;
         pay_sr     <= '0;
         crc_sr     <= '0;
         lfsr       <= CRC_INIT;
         mode_q     <= 1'b0;
         data_out   <= '0;
         crc_rx     <= '0;
         crc_calc   <= '0;
         data_valid <= 1'b0;
         crc_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (start_vld) begin
            pay_sr <= pay_nxt;
            lfsr   <= lfsr_nxt;
            mode_q <= mode;
            cnt    <= CNT_W'(1);
            state  <= PAYLOAD;
            busy   <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  busy <= 1'b0;
               end
               PAYLOAD: begin
                  if (serial_valid) begin
                     pay_sr <= pay_nxt;
                     lfsr   <= lfsr_nxt;
                     if (cnt == CNT_W'(PAYLOAD_W - 1)) begin
                        cnt <= '0;
                        if (mode_q) begin
                           state <= CRC;
                        end else begin
                           data_out   <= pay_nxt;
                           crc_rx     <= '0;
                           crc_calc   <= lfsr_nxt;
                           crc_err    <= 1'b0;
                           data_valid <= 1'b1;
                           state      <= DONE;
                        end
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               CRC: begin
                  if (serial_valid) begin
                     crc_sr <= crc_nxt;
                     if (cnt == CNT_W'(CRC_W - 1)) begin
                        cnt        <= '0;
                        data_out   <= pay_sr;
                        crc_rx     <= crc_nxt;
                        crc_calc   <= lfsr;
                        crc_err    <= (crc_nxt != lfsr);
                        data_valid <= 1'b1;
                        state      <= DONE;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_des_crc_rx.sv
// Randomized scoreboard bench for des_crc_rx against a polynomial-division CRC model.
module tb_des_crc_rx;
   import des_crc_rx_pkg::*;

   logic        clk;
   logic        rstn;
   logic        mode;
   logic        frame_start;
   logic        serial_valid;
   logic        serial_in;
   logic [31:0] data_out;
   logic [15:0] crc_rx;
   logic [15:0] crc_calc;
   logic        data_valid;
   logic        crc_err;
   logic        busy;

   typedef struct {
      logic [31:0] d;
      logic [15:0] cr;
      logic [15:0] cc;
      logic        e;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   des_crc_rx dut (
      .clk          (clk),
      .rstn         (rstn),
      .mode         (mode),
      .frame_start  (frame_start),
      .serial_valid (serial_valid),
      .serial_in    (serial_in),
      .data_out     (data_out),
      .crc_rx       (crc_rx),
      .crc_calc     (crc_calc),
      .data_valid   (data_valid),
      .crc_err      (crc_err),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // CRC as the remainder of (M*x^16 + INIT*x^32) divided by x^16+POLY.
   function automatic logic [15:0] model_crc(input logic [31:0] d);
      logic [47:0] v;
      logic [47:0] g;
      v = {d, 16'h0000} ^ {CRC_INIT, 32'h0};
      g = {31'b0, 1'b1, CRC_POLY};
      for (int i = 47; i >= 16; i--)
         if (v[i]) v = v ^ (g << (i - 16));
      return v[15:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rstn && data_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got data_valid=1 data_out=%h want no frame (t=%0t)",
                     data_out, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("data_out", data_out, e.d);
            chk("crc_rx", {16'h0, crc_rx}, {16'h0, e.cr});
            chk("crc_calc", {16'h0, crc_calc}, {16'h0, e.cc});
            chk("crc_err", {31'h0, crc_err}, {31'h0, e.e});
            chk("latency_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic idle(input int n, input bit rnd);
      repeat (n) begin
         @(posedge clk); #1;
         frame_start  = 1'b0;
         serial_valid = rnd ? 1'($urandom_range(1)) : 1'b0;
         serial_in    = 1'($urandom_range(1));
         mode         = 1'($urandom_range(1));
      end
   endtask

   // abort_at>0 drives only that many bits and expects no completion.
   task automatic send(input logic [31:0] pay, input logic m, input logic [15:0] cf,
                       input int gap_pct, input int abort_at);
      int   nbits;
      exp_t e;
      nbits = m ? 48 : 32;
      if (abort_at > 0) nbits = abort_at;
      for (int i = 0; i < nbits; i++) begin
         @(posedge clk); #1;
         if (i > 0) chk("busy_in_frame", {31'h0, busy}, 32'h1);
         while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            frame_start  = (i == 0) ? 1'($urandom_range(1)) : 1'b0;
            serial_valid = 1'b0;
            serial_in    = 1'($urandom_range(1));
            mode         = 1'($urandom_range(1));
            @(posedge clk); #1;
            if (i > 0) chk("busy_in_gap", {31'h0, busy}, 32'h1);
         end
         frame_start  = (i == 0);
         serial_valid = 1'b1;
         serial_in    = (i < 32) ? pay[31-i] : cf[15-(i-32)];
         mode         = (i == 0) ? m : 1'($urandom_range(1));
      end
      if (abort_at == 0) begin
         e.d   = pay;
         e.cr  = m ? cf : 16'h0;
         e.cc  = model_crc(pay);
         e.e   = m && (cf != model_crc(pay));
         e.cyc = cyc + 1;
         sb.push_back(e);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_data_out"}, data_out, 32'h0);
      chk({tag, "_crc_rx"}, {16'h0, crc_rx}, 32'h0);
      chk({tag, "_crc_calc"}, {16'h0, crc_calc}, 32'h0);
      chk({tag, "_data_valid"}, {31'h0, data_valid}, 32'h0);
      chk({tag, "_crc_err"}, {31'h0, crc_err}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
   endtask

   initial begin
      logic [31:0] p;
      logic        m;
      logic [15:0] c;
      rstn = 1'b0; mode = 1'b0; frame_start = 1'b0; serial_valid = 1'b0; serial_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rstn = 1'b1;
      idle(3, 1'b1);

      send(32'h12345678, 1'b1, model_crc(32'h12345678), 0, 0);
      send(32'h12345678, 1'b1, model_crc(32'h12345678) ^ 16'h0001, 0, 0);
      idle(2, 1'b0);
      send(32'hDEADBEEF, 1'b0, 16'h0000, 0, 0);
      idle(1, 1'b0);
      send(32'h12345678, 1'b1, model_crc(32'h12345678), 50, 0);
      idle(2, 1'b0);

      send($urandom, 1'b1, 16'h0000, 0, 20);
      send(32'hA5A5A5A5, 1'b1, model_crc(32'hA5A5A5A5), 0, 0);
      idle(2, 1'b0);

      for (int k = 0; k < 20; k++) begin
         p = $urandom;
         m = 1'($urandom_range(1));
         c = model_crc(p);
         if ($urandom_range(3) == 0) c = c ^ (16'h1 << $urandom_range(15));
         send(p, m, c, ($urandom_range(1) == 1) ? 40 : 0, 0);
         if ($urandom_range(1) == 1) idle(int'($urandom_range(3)), 1'b0);
      end

      send($urandom, 1'b1, 16'h0000, 30, 10);
      #2;
      rstn = 1'b0;
      #1;
      chk_zero("midreset");
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      idle(50, 1'b1);

      send(32'h0F0F1234, 1'b1, model_crc(32'h0F0F1234), 20, 0);
      idle(10, 1'b0);
      chk("scoreboard_empty", sb.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
